// File: rtl/traffic_light_multi_if.sv
// traffic_light_multi_if: request inputs and lamp outputs of traffic_light_multi.
// The master side drives flash/ped_req and the slave (controller) drives the lamps.
interface traffic_light_multi_if #(
   parameter int NUM_DIRS = 4
);
   localparam int DIR_W = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;

   logic                flash;
   logic [NUM_DIRS-1:0] ped_req;
   logic [NUM_DIRS-1:0] red;
   logic [NUM_DIRS-1:0] yellow;
   logic [NUM_DIRS-1:0] green;
   logic [NUM_DIRS-1:0] walk;
   logic [DIR_W-1:0]    active_dir;

   modport master (output flash, ped_req,
                   input  red, yellow, green, walk, active_dir);
   modport slave  (input  flash, ped_req,
                   output red, yellow, green, walk, active_dir);
endinterface

// File: rtl/traffic_light_multi.sv
// traffic_light_multi: round-robin signal controller for NUM_DIRS approaches.
// GREEN -> YELLOW -> ALLRED -> GREEN(next dir), with a flashing-yellow mode.
// Optional macro TRAFFIC_PED_EN adds sticky pedestrian latches and walk lamps.
module traffic_light_multi #(
   parameter int          NUM_DIRS      = 4,
   parameter int unsigned GREEN_CYCLES  = 160000000,
   parameter int unsigned YELLOW_CYCLES = 48000000,
   parameter int unsigned ALLRED_CYCLES = 16000000,
   parameter int unsigned FLASH_CYCLES  = 8000000,
   parameter int          CNT_W         = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   traffic_light_multi_if.slave tl_s
);
   localparam int DIR_W = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
   localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYCLES);
   localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYCLES);
   localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_CYCLES);
   localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);

   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    tmr_q, tmr_d;     // cycles left in state, 1 = final cycle
   logic [DIR_W-1:0]    dir_q, dir_d;
   logic                zero_q, zero_d;   // next green restarts at dir 0 (after FLASH)
   logic                fon_q, fon_d;     // flashing yellow currently lit
   logic [NUM_DIRS-1:0] red_q, yellow_q, green_q;
   logic [NUM_DIRS-1:0] red_d, yellow_d, green_d, onehot_d;
   logic                last;

   assign last = (tmr_q == CNT_W'(1));

   // Next-state, timer and direction decision
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q - 1'b1;
      dir_d   = dir_q;
      zero_d  = zero_q;
      fon_d   = fon_q;
      case (state_q)
         S_GREEN: begin
            // flash truncates green immediately
            if (tl_s.flash || last) begin
               state_d = S_YELLOW;
               tmr_d   = T_YELLOW;
            end
         end
         S_YELLOW: begin
            if (last) begin
               state_d = S_ALLRED;
               tmr_d   = T_ALLRED;
            end
         end
         S_ALLRED: begin
            if (last) begin
               if (tl_s.flash) begin
                  state_d = S_FLASH;
                  tmr_d   = T_FLASH;
                  fon_d   = 1'b1;
               end else begin
                  state_d = S_GREEN;
                  tmr_d   = T_GREEN;
                  dir_d   = (zero_q || dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
                  zero_d  = 1'b0;
               end
            end
         end
         default: begin
            if (!tl_s.flash) begin
               state_d = S_ALLRED;
               tmr_d   = T_ALLRED;
               zero_d  = 1'b1;
               fon_d   = 1'b0;
            end else if (last) begin
               fon_d = ~fon_q;
               tmr_d = T_FLASH;
            end
         end
      endcase
   end

   // Lamp pattern for the upcoming state, registered below
   always_comb begin
      onehot_d = NUM_DIRS'(1) << dir_d;
      red_d    = '1;
      yellow_d = '0;
      green_d  = '0;
      case (state_d)
         S_GREEN: begin
            green_d = onehot_d;
            red_d   = ~onehot_d;
         end
         S_YELLOW: begin
            yellow_d = onehot_d;
            red_d    = ~onehot_d;
         end
         S_FLASH: begin
            red_d    = '0;
            yellow_d = {NUM_DIRS{fon_d}};
         end
         default: ;
      endcase
   end

   // FSM state and registered lamp outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_ALLRED;
         tmr_q    <= T_ALLRED;
         dir_q    <= LAST_DIR;
         zero_q   <= 1'b0;
         fon_q    <= 1'b0;
         red_q    <= '1;
         yellow_q <= '0;
         green_q  <= '0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         dir_q    <= dir_d;
         zero_q   <= zero_d;
         fon_q    <= fon_d;
         red_q    <= red_d;
         yellow_q <= yellow_d;
         green_q  <= green_d;
      end
   end

   assign tl_s.red        = red_q;
   assign tl_s.yellow     = yellow_q;
   assign tl_s.green      = green_q;
   assign tl_s.active_dir = dir_q;

`ifdef TRAFFIC_PED_EN
   logic [NUM_DIRS-1:0] ped_q, ped_d, pend, walk_q, walk_d;
   logic                enter_green;

   // a request landing on the entry edge is served by that same green
   assign pend        = ped_q | tl_s.ped_req;
   assign enter_green = (state_q == S_ALLRED) && (state_d == S_GREEN);

   // Latch consumption on green entry; walk held for the whole green
   always_comb begin
      ped_d  = pend;
      walk_d = '0;
      if (enter_green) begin
         walk_d = pend & onehot_d;
         ped_d  = pend & ~onehot_d;
      end else if (state_q == S_GREEN && state_d == S_GREEN) begin
         walk_d = walk_q;
      end
   end

   // Pedestrian latches and walk lamps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_q  <= '0;
         walk_q <= '0;
      end else begin
         ped_q  <= ped_d;
         walk_q <= walk_d;
      end
   end

   assign tl_s.walk = walk_q;
`else
   logic unused_ped;
   assign unused_ped = ^tl_s.ped_req;
   assign tl_s.walk  = '0;
`endif
endmodule

// File: doc/traffic_light_multi.md
TRAFFIC_LIGHT_MULTI -- requirements
Module: traffic_light_multi

Interface
REQ-001 Parameter NUM_DIRS, default 4, is the number of approach directions; legal range is 2..8.
REQ-002 Parameter GREEN_CYCLES, default 160000000, is the green duration in clk cycles (10 s at 16 MHz).
REQ-003 Parameter YELLOW_CYCLES, default 48000000, is the yellow duration in clk cycles.
REQ-004 Parameter ALLRED_CYCLES, default 16000000, is the all-red clearance duration in clk cycles.
REQ-005 Parameter FLASH_CYCLES, default 8000000, is the flash half-period in clk cycles.
REQ-006 Parameter CNT_W, default 32, is the timer width; every *_CYCLES value SHALL be >=1 and < 2^CNT_W.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 flash  input  1  synchronous request for flashing-yellow mode.
REQ-010 ped_req  input  NUM_DIRS  per-direction pedestrian request, one bit per direction.
REQ-011 red  output  NUM_DIRS  per-direction red lamp.
REQ-012 yellow  output  NUM_DIRS  per-direction yellow lamp.
REQ-013 green  output  NUM_DIRS  per-direction green lamp.
REQ-014 walk  output  NUM_DIRS  per-direction pedestrian walk lamp.
REQ-015 active_dir  output  clog2(NUM_DIRS), minimum 1  index of the current direction.

Function
REQ-016 The FSM SHALL have four states: GREEN, YELLOW, ALLRED and FLASH; all outputs SHALL be registered.
REQ-017 Each timed state SHALL last exactly its *_CYCLES count: the timer loads on entry and the exit fires when the timer reaches its terminal value.
REQ-018 Normal transitions: GREEN -> YELLOW -> ALLRED -> GREEN(next direction).
REQ-019 The next direction SHALL be active_dir+1, wrapping from NUM_DIRS-1 to 0; active_dir changes only on ALLRED -> GREEN.
REQ-020 In GREEN or YELLOW, only bit active_dir SHALL show green or yellow respectively; all other directions SHALL show red.
REQ-021 In ALLRED, red SHALL be all ones and yellow and green SHALL be all zeros.
REQ-022 Outside FLASH, exactly one of red/yellow/green SHALL be set per direction, and at most one direction SHALL be non-red.
REQ-023 flash sampled high in GREEN SHALL truncate green and enter YELLOW with a full YELLOW_CYCLES period.
REQ-024 flash sampled high in YELLOW or ALLRED SHALL let the current state run to completion; ALLRED then exits to FLASH.
REQ-025 In FLASH, red and green SHALL be all zeros, and yellow SHALL be all ones or all zeros, toggling every FLASH_CYCLES and starting on.
REQ-026 flash sampled low in FLASH SHALL enter ALLRED for a full period, then GREEN with active_dir = 0.
REQ-027 If flash toggles within a state, only its value at the exit decision SHALL matter, except for the GREEN truncation in REQ-023.

Reset
REQ-028 Asserting rst SHALL immediately force state ALLRED, the timer loaded with ALLRED_CYCLES, active_dir = NUM_DIRS-1, red all ones, yellow/green/walk all zeros, and pedestrian latches cleared.
REQ-029 After rst deasserts, the block SHALL run ALLRED for ALLRED_CYCLES, then GREEN on direction 0.
REQ-030 Reset mid-operation SHALL abandon any state without passing through yellow.

Configuration
REQ-031 With macro TRAFFIC_PED_EN defined, each ped_req bit SHALL set a sticky pending latch.
REQ-032 With TRAFFIC_PED_EN, on entry to GREEN with the direction's latch set, walk[dir] SHALL assert for the whole green and the latch SHALL clear on entry.
REQ-033 With TRAFFIC_PED_EN, a request arriving during its own direction's green SHALL stay pending for that direction's next green.
REQ-034 With TRAFFIC_PED_EN, walk SHALL drop on exit from GREEN, SHALL be zero in YELLOW, ALLRED and FLASH, and pending latches SHALL be held through FLASH.
REQ-035 Without TRAFFIC_PED_EN, walk SHALL be constant zero, ped_req SHALL be ignored, and no latch registers SHALL exist.

Verification
Bench parameters: NUM_DIRS=3, GREEN=30, YELLOW=5, ALLRED=2, FLASH=4.
REQ-036 Release rst at t0: all red for 2 cycles, green[0] for 30, yellow[0] for 5, all red for 2, then green[1]; active_dir sequence 2,0,1,2,0 with a 111-cycle period.
REQ-037 Pulse flash for 1 cycle at green[1] cycle 10 and hold it high: yellow[1] for 5, all red for 2, then yellow all ones for 4 and off for 4, repeating.
REQ-038 Drop flash in FLASH: all red for 2 cycles, then green[0], regardless of the pre-flash direction.
REQ-039 Assert rst during yellow[2]: the same cycle shows red all ones and no yellow, and after release green[0] follows 2 cycles later.
REQ-040 With TRAFFIC_PED_EN, pulse ped_req[2] during green[0]: walk[2] is high for exactly the 30 cycles of green[2].
REQ-041 With TRAFFIC_PED_EN, a ped_req[2] pulse during green[2] produces walk[2] only on the following green[2], 111 cycles later.
